irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Machine-level external interrupt arbiter sitting between the peripheral interrupt lines and the interrupt-manager/CSR path. Latches pending requests from up to N_SRC sources and selects the highest-priority enabled one above a threshold. Presents it with an mcause-ready code and runs a claim/complete handshake, so only one external interrupt is in service at a time. Configured through a small register port driven by the CSR/MMIO write path.

## Interface
Parameters:
- N_SRC, 8, number of interrupt sources (2..32)
- PRIO_W, 3, priority field width; priority 0 means never taken
- ID_W, $clog2(N_SRC), source index width

Ports:
- clk  in  1  system clock
- clr_n  in  1  reset; asynchronous, active-low
- src_irq  in  N_SRC  raw interrupt lines, synchronous to clk
- global_int_en  in  1  mstatus.MIE; 0 blocks presentation
- cfg_we  in  1  config write strobe
- cfg_addr  in  8  config register address
- cfg_wdata  in  32  config write data
- cfg_rdata  out  32  combinational read of cfg_addr
- irq_req  out  1  interrupt presented
- irq_id  out  ID_W  presented source index
- irq_cause  out  32  32'h8000_0010 + irq_id
- irq_claim  in  1  one-cycle claim pulse from the interrupt manager
- irq_complete  in  1  one-cycle completion pulse
- complete_id  in  ID_W  source being completed
- busy  out  1  a source is in service

## Operation
- Config map:
  - 0x00 enable mask [N_SRC-1:0]
  - 0x01 edge-mode mask (1 = rising-edge, 0 = level)
  - 0x02 threshold [PRIO_W-1:0]
  - 0x10+i priority of source i
  - Unmapped reads return 0; unmapped writes are ignored.
  - All config registers reset to 0.
- Pending:
  - Edge source: pending bit sets on a sampled 0->1 (src_irq vs 1-cycle delayed copy). It clears on claim of that source. If a set and a claim hit the same source in the same cycle, the set wins.
  - Level source: pending = src_irq, except masked while that source is in service.
- Eligible: pending & enabled & prio > threshold.
- Winner: highest priority; ties go to the lowest index.
- FSM, states IDLE, PRESENT, IN_SERVICE:
  - IDLE -> PRESENT when an eligible source exists and global_int_en=1. Register irq_id and irq_cause.
  - PRESENT: re-arbitrate every cycle; irq_id follows the current winner.
    - No eligible source, or global_int_en=0 -> IDLE.
    - irq_claim -> IN_SERVICE. The current irq_id is captured as the service id.
  - IN_SERVICE: irq_req=0, busy=1. irq_complete with complete_id == service id -> IDLE. A mismatched id is ignored.
  - irq_claim outside PRESENT and irq_complete outside IN_SERVICE are ignored.
- Disabling the in-service source does not abort service; it waits for complete.
- A config write in the same cycle as arbitration takes effect from the next cycle.

## Timing
- Reset values: all outputs 0; state IDLE; pending bits and delay registers 0.
- Reset is asynchronous in both assertion and release. Mid-service reset returns to IDLE with nothing pending.
- Edge latency: src_irq sampled high at edge k -> pending after k -> irq_req=1 after edge k+1.
- Level latency: same, 2 edges.
- irq_req deasserts after the claim edge.
- irq_id may change only while irq_req=1 and no claim is sampled.
- Complete sampled at edge m -> IDLE after m. A new irq_req is possible after m+1.
- cfg_rdata is combinational, with no write bypass.

## Structure
- Shared package (alongside the codebase's define file) holds:
  - config address constants
  - FSM state encoding
  - cause base 32'h8000_0010
- Sub-module irq_prio_tree: combinational max-priority/lowest-index selector over eligible vectors.
- Parent holds config registers, pending logic and FSM.

## Test plan
- Edge source 2, prio 3, threshold 0, enabled, gie=1: pulse src_irq[2] one cycle -> irq_req high 2 edges later, irq_id=2, irq_cause=32'h8000_0012. Claim -> irq_req 0, busy 1. Complete id 2 -> busy 0, no re-request.
- Sources 1 and 5 both prio 4, plus source 3 prio 6, asserted together -> irq_id=3. After claim+complete, irq_id=1. Then irq_id=5.
- Level source 4 held high, prio 2, threshold 2 -> never presented. Set threshold 1 -> presented next cycle+1. Drop the line before claim -> irq_req falls, FSM returns to IDLE.
- While IN_SERVICE (id 0): complete with id 1 -> ignored, busy stays 1. New edge on source 0 during service -> pending; presented again right after the correct complete.
- PRESENT with id 6, then higher-priority source 7 edge arrives -> irq_id switches to 7 before claim. Claim then captures 7; source 6 stays pending.
- Assert clr_n low mid-IN_SERVICE (async, between edges) -> all outputs 0 immediately. Config cleared; nothing presented after release.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg: shared config map, FSM encoding and mcause base for the interrupt arbiter
package irq_arbiter_pkg;

    localparam logic [7:0]  ADDR_EN    = 8'h00;
    localparam logic [7:0]  ADDR_EDGE  = 8'h01;
    localparam logic [7:0]  ADDR_THR   = 8'h02;
    localparam logic [7:0]  ADDR_PRIO  = 8'h10;
    localparam logic [31:0] CAUSE_BASE = 32'h8000_0010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_SERVICE
    } irq_state_e;

    function automatic logic [31:0] irq_cause_of(input logic [4:0] id);
        return CAUSE_BASE + {27'b0, id};
    endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: config register port plus the interrupt claim/complete handshake
interface irq_arbiter_if #(parameter int ID_W = 3);
    logic            cfg_we;
    logic [7:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic [31:0]     irq_cause;
    logic            irq_claim;
    logic            irq_complete;
    logic [ID_W-1:0] complete_id;
    logic            busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, irq_claim, irq_complete, complete_id,
        input  cfg_rdata, irq_req, irq_id, irq_cause, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, irq_claim, irq_complete, complete_id,
        output cfg_rdata, irq_req, irq_id, irq_cause, busy
    );
endinterface

// File: rtl/irq_prio_tree.sv
// irq_prio_tree: selects the highest-priority eligible source, lowest index winning ties
module irq_prio_tree #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0]             elig,
    input  logic [N_SRC-1:0][PRIO_W-1:0] prio,
    output logic                         vld,
    output logic [ID_W-1:0]              id
);
    logic [PRIO_W-1:0] best;

    // ascending scan with a strict compare keeps the lowest index among equal priorities
    always_comb begin
        vld  = 1'b0;
        id   = '0;
        best = '0;
        for (int i = 0; i < N_SRC; i++)
            if (elig[i] && (!vld || prio[i] > best)) begin
                vld  = 1'b1;
                id   = ID_W'(i);
                best = prio[i];
            end
    end
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: latches external interrupt requests, arbitrates by priority and runs claim/complete
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             global_int_en,
    irq_arbiter_if.slave     bus
);
    logic [N_SRC-1:0]             en_q, edge_q, src_d, pend_q, clr, mask, elig;
    logic [PRIO_W-1:0]            thr_q;
    logic [N_SRC-1:0][PRIO_W-1:0] prio_q;
    logic [ID_W-1:0]              svc_id, win_id;
    logic                         win_vld;
    irq_state_e                   state;

    // config register writes; a write lands at the edge so arbitration sees it from the next cycle
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            en_q   <= '0;
            edge_q <= '0;
            thr_q  <= '0;
            prio_q <= '0;
        end else if (bus.cfg_we) begin
            if (bus.cfg_addr == ADDR_EN)   en_q   <= bus.cfg_wdata[N_SRC-1:0];
            if (bus.cfg_addr == ADDR_EDGE) edge_q <= bus.cfg_wdata[N_SRC-1:0];
            if (bus.cfg_addr == ADDR_THR)  thr_q  <= bus.cfg_wdata[PRIO_W-1:0];
            for (int i = 0; i < N_SRC; i++)
                if (bus.cfg_addr == ADDR_PRIO + 8'(i)) prio_q[i] <= bus.cfg_wdata[PRIO_W-1:0];
        end

    // combinational config readback, unmapped addresses read as zero
    always_comb begin
        bus.cfg_rdata = '0;
        if (bus.cfg_addr == ADDR_EN)   bus.cfg_rdata = 32'(en_q);
        if (bus.cfg_addr == ADDR_EDGE) bus.cfg_rdata = 32'(edge_q);
        if (bus.cfg_addr == ADDR_THR)  bus.cfg_rdata = 32'(thr_q);
        for (int i = 0; i < N_SRC; i++)
            if (bus.cfg_addr == ADDR_PRIO + 8'(i)) bus.cfg_rdata = 32'(prio_q[i]);
    end

    // claim clears the presented edge source; an in-service level source is hidden from arbitration
    always_comb begin
        clr  = '0;
        mask = '0;
        elig = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i]  = state == ST_PRESENT && bus.irq_claim && bus.irq_id == ID_W'(i);
            mask[i] = state == ST_SERVICE && svc_id == ID_W'(i) && !edge_q[i];
            elig[i] = pend_q[i] && en_q[i] && prio_q[i] > thr_q && !mask[i];
        end
    end

    // pending: edge sources latch a rising edge (set beats claim), level sources track the line
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            src_d  <= '0;
            pend_q <= '0;
        end else begin
            src_d  <= src_irq;
            pend_q <= (edge_q & ((src_irq & ~src_d) | (pend_q & ~clr))) | (~edge_q & src_irq);
        end

    irq_prio_tree #(.N_SRC(N_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) u_tree (
        .elig (elig),
        .prio (prio_q),
        .vld  (win_vld),
        .id   (win_id)
    );

    // arbitration FSM; a claim takes precedence over the winner disappearing in the same cycle
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            state         <= ST_IDLE;
            svc_id        <= '0;
            bus.irq_req   <= 1'b0;
            bus.irq_id    <= '0;
            bus.irq_cause <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:
                    if (win_vld && global_int_en) begin
                        state         <= ST_PRESENT;
                        bus.irq_req   <= 1'b1;
                        bus.irq_id    <= win_id;
                        bus.irq_cause <= irq_cause_of(5'(win_id));
                    end
                ST_PRESENT:
                    if (bus.irq_claim) begin
                        state       <= ST_SERVICE;
                        svc_id      <= bus.irq_id;
                        bus.irq_req <= 1'b0;
                        bus.busy    <= 1'b1;
                    end else if (!win_vld || !global_int_en) begin
                        state       <= ST_IDLE;
                        bus.irq_req <= 1'b0;
                    end else begin
                        bus.irq_id    <= win_id;
                        bus.irq_cause <= irq_cause_of(5'(win_id));
                    end
                ST_SERVICE:
                    if (bus.irq_complete && bus.complete_id == svc_id) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                default: state <= ST_IDLE;
            endcase
        end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed test-plan scenarios plus randomized traffic against a behavioural model
module tb_irq_arbiter;
    localparam int N = 8;
    localparam logic [31:0] CB = 32'h8000_0010;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [N-1:0] src_irq = '0;
    logic       gie = 1'b0;
    bit         chk_en = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    irq_arbiter_if #(.ID_W(3)) bus();

    irq_arbiter #(.N_SRC(N), .PRIO_W(3)) dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .src_irq       (src_irq),
        .global_int_en (gie),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // behavioural model state
    bit [N-1:0] m_en, m_edge, m_prev, m_pend;
    int         m_thr;
    int         m_prio [N];
    bit         m_presenting, m_serving;
    int         m_id, m_svc;
    logic [31:0] m_cause;

    task automatic model_reset();
        m_en = '0; m_edge = '0; m_prev = '0; m_pend = '0; m_thr = 0;
        for (int i = 0; i < N; i++) m_prio[i] = 0;
        m_presenting = 0; m_serving = 0; m_id = 0; m_svc = 0; m_cause = '0;
    endtask

    function automatic bit m_elig(int i);
        return m_pend[i] && m_en[i] && m_prio[i] > m_thr &&
               !(m_serving && m_svc == i && !m_edge[i]);
    endfunction

    function automatic int m_winner();
        int top = 0;
        for (int i = 0; i < N; i++) if (m_elig(i) && m_prio[i] > top) top = m_prio[i];
        if (top == 0) return -1;
        for (int i = 0; i < N; i++) if (m_elig(i) && m_prio[i] == top) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_rdata(logic [7:0] a);
        if (a == 8'h00) return {24'b0, m_en};
        if (a == 8'h01) return {24'b0, m_edge};
        if (a == 8'h02) return 32'(m_thr);
        if (a >= 8'h10 && a < 8'h18) return 32'(m_prio[a - 8'h10]);
        return 32'h0;
    endfunction

    task automatic model_step();
        int w;
        bit [N-1:0] rise;
        w = m_winner();
        rise = src_irq & ~m_prev;
        for (int i = 0; i < N; i++)
            if (m_edge[i]) m_pend[i] = rise[i] || (m_pend[i] && !(m_presenting && bus.irq_claim && m_id == i));
            else m_pend[i] = src_irq[i];
        if (m_presenting) begin
            if (bus.irq_claim) begin
                m_presenting = 0; m_serving = 1; m_svc = m_id;
            end else if (w < 0 || !gie) m_presenting = 0;
            else begin
                m_id = w; m_cause = CB + 32'(w);
            end
        end else if (m_serving) begin
            if (bus.irq_complete && int'(bus.complete_id) == m_svc) m_serving = 0;
        end else if (w >= 0 && gie) begin
            m_presenting = 1; m_id = w; m_cause = CB + 32'(w);
        end
        if (bus.cfg_we) begin
            if (bus.cfg_addr == 8'h00) m_en = bus.cfg_wdata[N-1:0];
            if (bus.cfg_addr == 8'h01) m_edge = bus.cfg_wdata[N-1:0];
            if (bus.cfg_addr == 8'h02) m_thr = int'(bus.cfg_wdata[2:0]);
            if (bus.cfg_addr >= 8'h10 && bus.cfg_addr < 8'h18) m_prio[bus.cfg_addr - 8'h10] = int'(bus.cfg_wdata[2:0]);
        end
        m_prev = src_irq;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // every-cycle comparison of DUT outputs against the model
    always @(negedge clk)
        if (chk_en) begin
            chk("irq_req", 32'(bus.irq_req), 32'(m_presenting));
            chk("busy", 32'(bus.busy), 32'(m_serving));
            chk("irq_id", 32'(bus.irq_id), 32'(m_id));
            chk("irq_cause", bus.irq_cause, m_cause);
            chk("cfg_rdata", bus.cfg_rdata, m_rdata(bus.cfg_addr));
        end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (clr_n) model_step();
            #1;
        end
    endtask

    task automatic do_reset();
        #2;
        clr_n = 1'b0;
        src_irq = '0; gie = 1'b0;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.irq_claim = 0; bus.irq_complete = 0; bus.complete_id = '0;
        model_reset();
        @(posedge clk);
        #3 clr_n = 1'b1;
    endtask

    task automatic wr(logic [7:0] a, logic [31:0] d);
        bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 0;
    endtask

    task automatic claim();
        bus.irq_claim = 1;
        tick();
        bus.irq_claim = 0;
    endtask

    task automatic complete(int id);
        bus.irq_complete = 1; bus.complete_id = 3'(id);
        tick();
        bus.irq_complete = 0;
    endtask

    task automatic pulse(logic [N-1:0] m);
        src_irq = m;
        tick();
        src_irq = '0;
    endtask

    task automatic cfg_rand();
        wr(8'h00, $urandom);
        wr(8'h01, $urandom);
        wr(8'h02, $urandom % 3);
        for (int i = 0; i < N; i++) wr(8'h10 + 8'(i), $urandom);
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.irq_claim = 0; bus.irq_complete = 0; bus.complete_id = '0;
        model_reset();
        #1 chk_en = 1;
        #1 chk("rst_req", 32'(bus.irq_req), 0);
        chk("rst_cause", bus.irq_cause, 0);
        @(posedge clk);
        #3 clr_n = 1'b1;

        // single edge source
        do_reset(); gie = 1;
        wr(8'h00, 32'h04); wr(8'h01, 32'h04); wr(8'h12, 3);
        pulse(8'h04);
        chk("t1_req_early", 32'(bus.irq_req), 0);
        tick();
        chk("t1_req", 32'(bus.irq_req), 1);
        chk("t1_id", 32'(bus.irq_id), 2);
        chk("t1_cause", bus.irq_cause, 32'h8000_0012);
        claim();
        chk("t1_claim_req", 32'(bus.irq_req), 0);
        chk("t1_claim_busy", 32'(bus.busy), 1);
        tick(2);
        complete(2);
        chk("t1_done_busy", 32'(bus.busy), 0);
        tick(3);
        chk("t1_no_rereq", 32'(bus.irq_req), 0);

        // priority order and lowest-index tie break
        do_reset(); gie = 1;
        wr(8'h00, 32'h2A); wr(8'h01, 32'h2A);
        wr(8'h11, 4); wr(8'h15, 4); wr(8'h13, 6);
        pulse(8'h2A); tick();
        chk("t2_first", 32'(bus.irq_id), 3);
        claim(); complete(3); tick();
        chk("t2_second", 32'(bus.irq_id), 1);
        chk("t2_second_req", 32'(bus.irq_req), 1);
        claim(); complete(1); tick();
        chk("t2_third", 32'(bus.irq_id), 5);
        claim(); complete(5); tick(2);
        chk("t2_drained", 32'(bus.irq_req), 0);

        // level source against threshold
        do_reset(); gie = 1;
        wr(8'h00, 32'h10); wr(8'h14, 2); wr(8'h02, 2);
        src_irq = 8'h10;
        tick(5);
        chk("t3_below_thr", 32'(bus.irq_req), 0);
        wr(8'h02, 1);
        chk("t3_write_cycle", 32'(bus.irq_req), 0);
        tick();
        chk("t3_req", 32'(bus.irq_req), 1);
        chk("t3_id", 32'(bus.irq_id), 4);
        src_irq = '0;
        tick();
        chk("t3_still", 32'(bus.irq_req), 1);
        tick();
        chk("t3_dropped", 32'(bus.irq_req), 0);

        // mismatched complete and re-pend during service
        do_reset(); gie = 1;
        wr(8'h00, 32'h01); wr(8'h01, 32'h01); wr(8'h10, 5);
        pulse(8'h01); tick();
        chk("t4_id", 32'(bus.irq_id), 0);
        claim();
        complete(1);
        chk("t4_wrong_id", 32'(bus.busy), 1);
        pulse(8'h01); tick();
        chk("t4_in_service", 32'(bus.irq_req), 0);
        complete(0);
        chk("t4_busy_clear", 32'(bus.busy), 0);
        tick();
        chk("t4_represent", 32'(bus.irq_req), 1);
        chk("t4_represent_id", 32'(bus.irq_id), 0);

        // preemption before claim
        do_reset(); gie = 1;
        wr(8'h00, 32'hC0); wr(8'h01, 32'hC0); wr(8'h16, 3); wr(8'h17, 5);
        pulse(8'h40); tick();
        chk("t5_id6", 32'(bus.irq_id), 6);
        pulse(8'h80);
        chk("t5_id6_hold", 32'(bus.irq_id), 6);
        tick();
        chk("t5_id7", 32'(bus.irq_id), 7);
        chk("t5_cause7", bus.irq_cause, 32'h8000_0017);
        claim(); complete(7); tick();
        chk("t5_six_left", 32'(bus.irq_id), 6);
        chk("t5_six_req", 32'(bus.irq_req), 1);

        // asynchronous reset mid-service
        do_reset(); gie = 1;
        wr(8'h00, 32'h08); wr(8'h01, 32'h08); wr(8'h13, 5);
        pulse(8'h08); tick(); claim();
        bus.cfg_addr = 8'h13;
        #1 chk("t6_prio_rd", bus.cfg_rdata, 5);
        chk("t6_busy", 32'(bus.busy), 1);
        #1 clr_n = 1'b0;
        model_reset();
        #1 chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_id", 32'(bus.irq_id), 0);
        chk("t6_rst_cause", bus.irq_cause, 0);
        chk("t6_rst_cfg", bus.cfg_rdata, 0);
        @(posedge clk);
        #3 clr_n = 1'b1;
        pulse(8'h08); tick(3);
        chk("t6_after_req", 32'(bus.irq_req), 0);

        // randomized traffic
        do_reset(); gie = 1;
        cfg_rand();
        for (int k = 0; k < 4000; k++) begin
            if (k == 2000) begin
                do_reset(); gie = 1;
                cfg_rand();
            end
            bus.cfg_we = ($urandom % 100) < 5;
            case ($urandom % 5)
                0: bus.cfg_addr = 8'h00;
                1: bus.cfg_addr = 8'h01;
                2: bus.cfg_addr = 8'h02;
                3: bus.cfg_addr = 8'h10 + 8'($urandom % 8);
                default: bus.cfg_addr = 8'($urandom);
            endcase
            bus.cfg_wdata = $urandom;
            if (bus.cfg_addr == 8'h00) bus.cfg_wdata[7:0] = bus.cfg_wdata[7:0] | 8'($urandom);
            src_irq = src_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            gie = ($urandom % 16) != 0;
            bus.irq_claim = m_presenting ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
            bus.irq_complete = m_serving ? ($urandom % 4 == 0) : ($urandom % 20 == 0);
            bus.complete_id = ($urandom % 3 == 0) ? 3'($urandom) : 3'(m_svc);
            tick();
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
